updown_sweep_ctrl: RTL

Sequencer for a WIDTH-bit up/down counter. On a start request it latches a low bound, high bound and sweep count, then drives the counter through continuous triangle sweeps lo→hi→lo. It generates the direction (mode) and count value each cycle and signals completion. It sits between a host/control FSM and any logic consuming the up/down count, replacing hand-toggled mode control.

---
 rtl/updown_sweep_ctrl_if.sv | 33 +++
 rtl/updown_sweep_ctrl.sv | 120 ++++++++++++
 2 files changed

// File: rtl/updown_sweep_ctrl_if.sv
// Host-side bundle for updown_sweep_ctrl: sweep request, bounds, hold and
// the count/status outputs. The abort line exists only when
// UPDOWN_SWEEP_ABORT_EN is defined.
interface updown_sweep_ctrl_if #(
  parameter int WIDTH  = 2,
  parameter int NCYC_W = 4
);
  logic              start;
  logic [WIDTH-1:0]  lo;
  logic [WIDTH-1:0]  hi;
  logic [NCYC_W-1:0] ncyc;
  logic              hold;
`ifdef UPDOWN_SWEEP_ABORT_EN
  logic              abort;
`endif
  logic [WIDTH-1:0]  q;
  logic              mode;
  logic              busy;
  logic              done;
  logic              err;

`ifdef UPDOWN_SWEEP_ABORT_EN
  modport master (output start, lo, hi, ncyc, hold, abort,
                  input  q, mode, busy, done, err);
  modport slave  (input  start, lo, hi, ncyc, hold, abort,
                  output q, mode, busy, done, err);
`else
  modport master (output start, lo, hi, ncyc, hold,
                  input  q, mode, busy, done, err);
  modport slave  (input  start, lo, hi, ncyc, hold,
                  output q, mode, busy, done, err);
`endif
endinterface

// File: rtl/updown_sweep_ctrl.sv
// Triangle sweep sequencer for an up/down counter: lo->hi->lo repeated
// ncyc times, with hold, completion pulse and rejected-start pulse.
// Optional feature: define UPDOWN_SWEEP_ABORT_EN to add an abort input that
// drops an active sweep back to IDLE without a done pulse.
//
// state | meaning
// IDLE  | waiting for start; q holds its last value
// UP    | q increments each unheld cycle until it reaches hi
// DOWN  | q decrements each unheld cycle until it reaches lo
// DONE  | one-cycle completion, done=1, q=lo
module updown_sweep_ctrl #(
  parameter int WIDTH  = 2,
  parameter int NCYC_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  updown_sweep_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, UP, DOWN, DONE} state_t;

  state_t            state;
  logic [WIDTH-1:0]  lo_r;
  logic [WIDTH-1:0]  hi_r;
  logic [NCYC_W-1:0] cnt_rem;
  logic [WIDTH-1:0]  q_r;
  logic              mode_r;
  logic              busy_r;
  logic              done_r;
  logic              err_r;

  // Outputs come straight from registers.
  assign bus.q    = q_r;
  assign bus.mode = mode_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.err  = err_r;

  // Sweep FSM with registered outputs; done/err default low so they pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      lo_r    <= '0;
      hi_r    <= '0;
      cnt_rem <= '0;
      q_r     <= '0;
      mode_r  <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if ((bus.lo >= bus.hi) || (bus.ncyc == '0)) begin
              err_r <= 1'b1;
            end else begin
              lo_r    <= bus.lo;
              hi_r    <= bus.hi;
              cnt_rem <= bus.ncyc;
              q_r     <= bus.lo;
              mode_r  <= 1'b1;
              busy_r  <= 1'b1;
              state   <= UP;
            end
          end
        end
        UP: begin
`ifdef UPDOWN_SWEEP_ABORT_EN
          if (bus.abort) begin
            state  <= IDLE;
            busy_r <= 1'b0;
            mode_r <= 1'b1;
          end else
`endif
          if (!bus.hold) begin
            q_r <= q_r + 1'b1;
            if (q_r == hi_r - 1'b1) begin
              state  <= DOWN;
              mode_r <= 1'b0;
            end
          end
        end
        DOWN: begin
`ifdef UPDOWN_SWEEP_ABORT_EN
          if (bus.abort) begin
            state  <= IDLE;
            busy_r <= 1'b0;
            mode_r <= 1'b1;
          end else
`endif
          if (!bus.hold) begin
            q_r <= q_r - 1'b1;
            // Reaching lo closes one full sweep; turn around or finish.
            if (q_r == lo_r + 1'b1) begin
              cnt_rem <= cnt_rem - 1'b1;
              mode_r  <= 1'b1;
              if (cnt_rem == NCYC_W'(1)) begin
                state  <= DONE;
                busy_r <= 1'b0;
                done_r <= 1'b1;
              end else begin
                state <= UP;
              end
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
